// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 5;

  // STATUS register image as returned on the load bus
  typedef struct packed {
    logic [22:0] rsvd;
    logic [4:0]  count;
    logic        ovf;
    logic        busy;
    logic        empty;
    logic        full;
  } status_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter; push is accepted when full
// only if a pop happens on the same edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head_data_c,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CNT_W-1:0]  count_d;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_d = count;
    if (do_push && !do_pop) begin
      count_d = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data_c = mem[rd_ptr];

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register pair, byte FIFO and
// serialiser FSM. Build option: UART_TX_PARITY_EN inserts an even-parity bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W = 3;

  tx_state_e          state_q;
  tx_state_e          state_d;
  logic [BAUD_W-1:0]  baud_q;
  logic [BAUD_W-1:0]  baud_d;
  logic [BIT_W-1:0]   bit_q;
  logic [BIT_W-1:0]   bit_d;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  shift_d;
  logic               tx_d;
  logic               baud_done;
`ifdef UART_TX_PARITY_EN
  logic               parity_q;
  logic               parity_d;
`endif

  logic               hit;
  logic               txdata_wr;
  logic               ovf_clr;
  logic               ovf_set;
  logic               ovf_q;
  status_t            status;

  logic               fifo_pop;
  logic [DATA_W-1:0]  fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_bits;

  assign unused_bits = ^{mem_addr[1:0], mem_write_data[31:DATA_W]};

  // Register decode; the low two address bits are don't-care
  always_comb begin
    hit       = (mem_addr[31:3] == BASE_ADDR[31:3]);
    txdata_wr = write_enable && hit && (mem_addr[2] == REG_TXDATA);
    ovf_clr   = write_enable && hit && (mem_addr[2] == REG_STATUS)
                && mem_write_data[STAT_OVF];
    ovf_set   = txdata_wr && fifo_full && !fifo_pop;
  end

  always_comb begin
    status       = '0;
    status.full  = fifo_full;
    status.empty = fifo_empty;
    status.busy  = (state_q != ST_IDLE);
    status.ovf   = ovf_q;
    status.count = STAT_CNT_W'(fifo_count);
    mem_read_data = (read_enable && hit && (mem_addr[2] == REG_STATUS))
                    ? 32'(status) : 32'h0;
  end

  assign irq = fifo_empty && (state_q == ST_IDLE);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (txdata_wr),
    .push_data   (mem_write_data[DATA_W-1:0]),
    .pop         (fifo_pop),
    .head_data_c (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    baud_done = (baud_q == '0);
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_START;
      ST_START: if (baud_done) state_d = ST_DATA;
      ST_DATA: begin
        if (baud_done && (bit_q == BIT_W'(DATA_W - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (baud_done) state_d = ST_STOP;
`endif
      // Back-to-back frames go straight to the next start bit
      ST_STOP:  if (baud_done) state_d = fifo_empty ? ST_IDLE : ST_START;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and registered serial output
  always_comb begin
    fifo_pop = 1'b0;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_d == ST_START && state_q != ST_START) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_head;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_head;
`endif
    end

    if (state_d != state_q) begin
      baud_d = (state_d == ST_IDLE) ? '0 : BAUD_LOAD;
      bit_d  = '0;
    end else if (state_q == ST_DATA && baud_done) begin
      baud_d  = BAUD_LOAD;
      bit_d   = bit_q + BIT_W'(1);
      shift_d = shift_q >> 1;
    end else if (!baud_done) begin
      baud_d = baud_q - BAUD_W'(1);
    end

    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: expected serial bits are queued at each
// store and popped as the line is sampled mid-bit.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned CPB  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        tx;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic exp_q[$];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .write_enable   (write_enable),
    .read_enable    (read_enable),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .tx             (tx),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_addr       = addr;
    mem_write_data = data;
    write_enable   = 1'b1;
    @(posedge clk);
    #1 write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    mem_addr    = addr;
    read_enable = 1'b1;
    #1 data     = mem_read_data;
    read_enable = 1'b0;
  endtask

  // Waits for a start bit, then samples n contiguous frames one cycle into each bit
  task automatic check_frames(input int n, input string tag, output int waited);
    int   nb;
    logic e;
    nb = n * int'(FRAME_BITS);
    waited = 0;
    @(negedge clk);
    while (tx !== 1'b0 && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    chk({tag, " start seen"}, 32'(tx), 32'd0);
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i != 0) repeat (CPB) @(negedge clk);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      chk($sformatf("%s bit%0d", tag, i), 32'(tx), 32'(e));
      chk($sformatf("%s irq_busy%0d", tag, i), 32'(irq), 32'd0);
    end
    repeat (CPB - 1) @(negedge clk);
    chk({tag, " line idle at end"}, 32'(tx), 32'd1);
    chk({tag, " irq at end"}, 32'(irq), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          w;
    int          lows;
    int          cyc;

    // Reset values
    #12;
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset irq", 32'(irq), 32'd1);
    bus_read(BASE + 32'h4, rd);
    chk("reset status", rd, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame 0x55 with latency check
    bus_write(BASE, 32'h55);
    push_frame(8'h55);
    bus_read(BASE + 32'h4, rd);
    chk("queued status", rd, 32'h10);
    chk("tx before start", 32'(tx), 32'd1);
    chk("irq with data queued", 32'(irq), 32'd0);
    check_frames(1, "f55", w);
    chk("f55 latency", 32'(w), 32'd0);

    bus_write(BASE, 32'hA3);
    push_frame(8'hA3);
    check_frames(1, "fA3", w);
    chk("fA3 latency", 32'(w), 32'd1);

    bus_write(BASE, 32'h07);
    push_frame(8'h07);
    check_frames(1, "f07", w);
    chk("f07 latency", 32'(w), 32'd1);

    // Two queued bytes: second start directly after first stop
    bus_write(BASE, 32'h3C);
    bus_write(BASE + 32'h3, 32'hC5);
    push_frame(8'h3C);
    push_frame(8'hC5);
    check_frames(2, "b2b", w);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // Overflow: one popped, four queued, sixth dropped
    for (int i = 0; i < 6; i++) bus_write(BASE, 32'h11 + 32'(i));
    bus_read(BASE + 32'h4, rd);
    chk("overflow status", rd, 32'h4D);
    bus_write(BASE + 32'h4, 32'h7);
    bus_read(BASE + 32'h4, rd);
    chk("status write without bit3", rd, 32'h4D);
    bus_write(BASE + 32'h4, 32'h8);
    bus_read(BASE + 32'h4, rd);
    chk("overflow cleared", rd, 32'h45);
    cyc = 0;
    while (irq !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain reached irq", 32'(irq), 32'd1);
    chk("drain duration", 32'(cyc >= 4 * 40 && cyc < 5 * 44), 32'd1);

    // Decode: out-of-window and disabled loads, out-of-window store
    bus_read(BASE + 32'h8, rd);
    chk("read base+8", rd, 32'h0);
    @(negedge clk);
    mem_addr = BASE + 32'h4;
    read_enable = 1'b0;
    #1 chk("read disabled", mem_read_data, 32'h0);
    bus_read(BASE, rd);
    chk("read txdata", rd, 32'h0);
    bus_write(BASE + 32'h8, 32'h99);
    bus_read(BASE + 32'h7, rd);
    chk("status after miss store", rd, 32'h2);
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no frame after miss store", 32'(lows), 32'd0);

    // Reset during data bit 3 aborts the frame
    bus_write(BASE, 32'h00);
    repeat (19) @(negedge clk);
    chk("mid-frame data bit", 32'(tx), 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("tx forced by reset", 32'(tx), 32'd1);
    chk("irq forced by reset", 32'(irq), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(BASE + 32'h4, rd);
    chk("status after abort", rd, 32'h2);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("no residual bits", 32'(lows), 32'd0);

    // Push on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    mem_addr       = BASE;
    mem_write_data = 32'h5A;
    write_enable   = 1'b1;
    rst_n          = 1'b1;
    @(posedge clk);
    #1 write_enable = 1'b0;
    push_frame(8'h5A);
    bus_read(BASE + 32'h4, rd);
    chk("first edge push", rd, 32'h10);
    check_frames(1, "f5A", w);
    chk("f5A latency", 32'(w), 32'd0);
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, byte address of the register window.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (legal range 2..65535).
REQ-003 Parameter FIFO_DEPTH, default 4, TX byte FIFO entries (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 write_enable  input  1  store strobe from the core data-bus.
REQ-007 read_enable  input  1  load strobe from the core data-bus.
REQ-008 mem_addr  input  32  byte address from the core ALU result.
REQ-009 mem_write_data  input  32  store data.
REQ-010 mem_read_data  output  32  load data, combinational.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 irq  output  1  high while FIFO empty and FSM idle (TX drained).

Function
REQ-013 Register hit when mem_addr[31:3] == BASE_ADDR[31:3]; offset = mem_addr[2]; mem_addr[1:0] ignored.
REQ-014 Offset 0 (TXDATA): write with hit pushes mem_write_data[7:0] into FIFO at the rising edge; read returns 0.
REQ-015 Offset 1 (STATUS) read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow, bits[8:4] FIFO count, others 0.
REQ-016 STATUS write with mem_write_data[3]=1 clears overflow; all other STATUS bits read-only.
REQ-017 mem_read_data = 0 when read_enable low or no hit; same-cycle read/write returns pre-edge values.
REQ-018 Push while full and no pop in same cycle: byte dropped, overflow set (sticky).
REQ-019 Push and pop in the same cycle: both performed, count unchanged, including when full.
REQ-020 FSM states IDLE, START, DATA, PARITY, STOP; each non-IDLE state lasts CLKS_PER_BIT cycles counted by a baud counter reloaded on every state entry.
REQ-021 IDLE -> START on the edge where FIFO is non-empty; FIFO head popped on that same edge into an 8-bit shift register.
REQ-022 tx: START drives 0; DATA drives shift register LSB-first, 8 bits, bit index 0..7 counter; STOP drives 1; IDLE drives 1.
REQ-023 DATA -> PARITY (macro defined) or STOP after bit 7; STOP -> START directly if FIFO non-empty (back-to-back frames, no idle gap), else IDLE.
REQ-024 Latency: byte pushed at edge N into empty FIFO with FSM IDLE -> tx falls after edge N+1.
REQ-025 tx registered; no combinational path from bus inputs to tx.
REQ-026 FIFO count width = clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 rst_n low immediately forces: tx=1, state IDLE, FIFO empty (pointers and count 0), overflow 0, baud and bit counters 0, irq=1.
REQ-028 Reset mid-frame aborts the frame; no partial frame resumes after release.
REQ-029 First push is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles; frame = 11 bits.
REQ-031 Macro undefined: PARITY state and its logic absent, DATA -> STOP; frame = 10 bits.

Structure
REQ-032 Package uart_pkg holds the FSM state enum, register offset constants (TXDATA=0, STATUS=1) and STATUS bit-position constants.
REQ-033 One sub-module uart_tx_fifo (synchronous FIFO, parameter DEPTH, width 8, push/pop/full/empty/count); FSM, baud counter and bus decode in mmio_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Write 0x55 to BASE_ADDR -> tx low after one edge, then 1,0,1,0,1,0,1,0 each 4 cycles, stop 1; 40 cycles total (44 with parity, parity bit 0).
REQ-035 Write 0xA3 with parity enabled -> data bits 1,1,0,0,0,1,0,1, parity bit 0; write 0x07 -> parity bit 1.
REQ-036 Write 6 bytes back-to-back -> 1 popped, 4 queued, 6th dropped, STATUS reads 0x4D (count 4, overflow, busy, full); write 0x8 to STATUS -> bit3 clears.
REQ-037 Queue 2 bytes -> second START begins on the cycle after first STOP ends, no idle gap; irq rises only after second STOP.
REQ-038 Assert rst_n low during DATA bit 3 -> tx=1 immediately, STATUS reads 0x2 after release, no residual bits.
REQ-039 Load from BASE_ADDR+8 or with read_enable=0 -> mem_read_data 0; store to BASE_ADDR+8 -> FIFO count unchanged.
